// File: rtl/wb_stage_if.sv
// MEM-to-writeback handshake bundle: retiring instruction fields plus the load response.
// The MEM side is the master and the writeback stage is the slave.
interface wb_stage_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      in_valid;
  logic                      in_ready;
  logic [REG_ADDR_WIDTH-1:0] in_rd_addr;
  logic                      in_rd_we;
  logic                      in_is_load;
  logic [2:0]                in_funct3;
  logic [1:0]                in_addr_lsb;
  logic [DATA_WIDTH-1:0]     in_result;
  logic                      mem_rsp_valid;
  logic [DATA_WIDTH-1:0]     mem_rsp_data;

  modport master (
    output in_valid, in_rd_addr, in_rd_we, in_is_load, in_funct3,
           in_addr_lsb, in_result, mem_rsp_valid, mem_rsp_data,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_rd_addr, in_rd_we, in_is_load, in_funct3,
           in_addr_lsb, in_result, mem_rsp_valid, mem_rsp_data,
    output in_ready
  );
endinterface

// File: rtl/wb_stage.sv
// rv32i writeback stage: retires one instruction per cycle into the register file,
// waits for and extends load data, and exposes forwarding/load-hazard status.
module wb_stage #(
  parameter int DATA_WIDTH       = 32,
  parameter int REG_ADDR_WIDTH   = 5,
  parameter int RETIRE_CNT_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  wb_stage_if.slave                   bus,
  output logic                        rf_write_en,
  output logic [REG_ADDR_WIDTH-1:0]   rf_rd_addr,
  output logic [DATA_WIDTH-1:0]       rf_rd_data,
  output logic                        fwd_valid,
  output logic                        load_pending,
  output logic [REG_ADDR_WIDTH-1:0]   load_rd_addr,
  output logic                        load_err,
  output logic [RETIRE_CNT_WIDTH-1:0] retire_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    HOLD     = 2'd2
  } state_t;

  state_t          state;
  logic            held_we;
  logic [2:0]      held_funct3;
  logic [1:0]      held_lsb;
  logic            accept;
  logic            rd_nonzero;
  logic            load_bad;
  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic [DATA_WIDTH-1:0] load_ext;

  localparam logic [RETIRE_CNT_WIDTH-1:0] RETIRE_ONE = {{(RETIRE_CNT_WIDTH-1){1'b0}}, 1'b1};

  assign bus.in_ready = (state != WAIT_MEM);
  assign accept       = bus.in_valid && (state != WAIT_MEM);
  assign rd_nonzero   = (bus.in_rd_addr != '0);
  assign fwd_valid    = rf_write_en;
  assign load_pending = (state == WAIT_MEM);
  assign load_rd_addr = rf_rd_addr;

  // Misaligned halves/words and the unused funct3 codes are flagged, but still complete.
  always_comb begin
    load_bad = 1'b0;
    case (bus.in_funct3)
      3'b001, 3'b101: load_bad = bus.in_addr_lsb[0];
      3'b010:         load_bad = (bus.in_addr_lsb != 2'b00);
      3'b011, 3'b110, 3'b111: load_bad = 1'b1;
      default:        load_bad = 1'b0;
    endcase
  end

  always_comb begin
    load_byte = bus.mem_rsp_data[7:0];
    case (held_lsb)
      2'd1:    load_byte = bus.mem_rsp_data[15:8];
      2'd2:    load_byte = bus.mem_rsp_data[23:16];
      2'd3:    load_byte = bus.mem_rsp_data[31:24];
      default: load_byte = bus.mem_rsp_data[7:0];
    endcase
    load_half = held_lsb[1] ? bus.mem_rsp_data[31:16] : bus.mem_rsp_data[15:0];
    case (held_funct3)
      3'b000:  load_ext = {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};
      3'b001:  load_ext = {{(DATA_WIDTH-16){load_half[15]}}, load_half};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, load_byte};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, load_half};
      default: load_ext = bus.mem_rsp_data;
    endcase
  end

  // Entering HOLD is the retire point: the write strobe and the counter update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      held_we      <= 1'b0;
      held_funct3  <= 3'b000;
      held_lsb     <= 2'b00;
      rf_write_en  <= 1'b0;
      rf_rd_addr   <= '0;
      rf_rd_data   <= '0;
      load_err     <= 1'b0;
      retire_count <= '0;
    end else begin
      rf_write_en <= 1'b0;
      load_err    <= 1'b0;
      case (state)
        WAIT_MEM: begin
          if (bus.mem_rsp_valid) begin
            rf_rd_data   <= load_ext;
            rf_write_en  <= held_we && (rf_rd_addr != '0);
            retire_count <= retire_count + RETIRE_ONE;
            state        <= HOLD;
          end
        end
        default: begin
          if (accept) begin
            rf_rd_addr <= bus.in_rd_addr;
            held_we    <= bus.in_rd_we;
            if (bus.in_is_load) begin
              held_funct3 <= bus.in_funct3;
              held_lsb    <= bus.in_addr_lsb;
              load_err    <= load_bad;
              state       <= WAIT_MEM;
            end else begin
              rf_rd_data   <= bus.in_result;
              rf_write_en  <= bus.in_rd_we && rd_nonzero;
              retire_count <= retire_count + RETIRE_ONE;
              state        <= HOLD;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a full-width instance plus a 4-bit retire counter copy
// fed by the same MEM-side stimulus.
module tb_wb_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_stage_if bus ();
  wb_stage_if bus_short ();

  logic        rf_write_en, fwd_valid, load_pending, load_err;
  logic [4:0]  rf_rd_addr, load_rd_addr;
  logic [31:0] rf_rd_data, retire_count;

  logic        s_write_en, s_fwd_valid, s_load_pending, s_load_err;
  logic [4:0]  s_rd_addr, s_load_rd_addr;
  logic [31:0] s_rd_data;
  logic [3:0]  s_retire_count;

  int checks = 0;
  int errors = 0;
  int exp_retire = 0;

  wb_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .rf_write_en  (rf_write_en),
    .rf_rd_addr   (rf_rd_addr),
    .rf_rd_data   (rf_rd_data),
    .fwd_valid    (fwd_valid),
    .load_pending (load_pending),
    .load_rd_addr (load_rd_addr),
    .load_err     (load_err),
    .retire_count (retire_count)
  );

  wb_stage #(.RETIRE_CNT_WIDTH(4)) dut_short (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus_short.slave),
    .rf_write_en  (s_write_en),
    .rf_rd_addr   (s_rd_addr),
    .rf_rd_data   (s_rd_data),
    .fwd_valid    (s_fwd_valid),
    .load_pending (s_load_pending),
    .load_rd_addr (s_load_rd_addr),
    .load_err     (s_load_err),
    .retire_count (s_retire_count)
  );

  assign bus_short.in_valid      = bus.in_valid;
  assign bus_short.in_rd_addr    = bus.in_rd_addr;
  assign bus_short.in_rd_we      = bus.in_rd_we;
  assign bus_short.in_is_load    = bus.in_is_load;
  assign bus_short.in_funct3     = bus.in_funct3;
  assign bus_short.in_addr_lsb   = bus.in_addr_lsb;
  assign bus_short.in_result     = bus.in_result;
  assign bus_short.mem_rsp_valid = bus.mem_rsp_valid;
  assign bus_short.mem_rsp_data  = bus.mem_rsp_data;

  task automatic applyStimulus(input logic valid, input logic [4:0] rd, input logic we,
                               input logic is_load, input logic [2:0] f3,
                               input logic [1:0] lsb, input logic [31:0] result);
    bus.in_valid    = valid;
    bus.in_rd_addr  = rd;
    bus.in_rd_we    = we;
    bus.in_is_load  = is_load;
    bus.in_funct3   = f3;
    bus.in_addr_lsb = lsb;
    bus.in_result   = result;
  endtask

  task automatic applyRsp(input logic valid, input logic [31:0] data);
    bus.mem_rsp_valid = valid;
    bus.mem_rsp_data  = data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkRetire(input string tag);
    checkOutput(tag, retire_count, exp_retire);
    checkOutput({tag, "_short"}, {28'd0, s_retire_count}, exp_retire % 16);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fall();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'b000, 2'b00, 32'h0);
    applyRsp(1'b0, 32'h0);
    repeat (2) fall();

    checkOutput("rst_in_ready", bus.in_ready, 1);
    checkOutput("rst_write_en", rf_write_en, 0);
    checkOutput("rst_rd_addr", rf_rd_addr, 0);
    checkOutput("rst_rd_data", rf_rd_data, 0);
    checkOutput("rst_load_pending", load_pending, 0);
    checkOutput("rst_load_err", load_err, 0);
    checkRetire("rst_retire");
    rst_n = 1'b1;

    // ADD x5 = 0x1234
    fall();
    applyStimulus(1'b1, 5'd5, 1'b1, 1'b0, 3'b000, 2'b00, 32'h0000_1234);
    tick();
    exp_retire = 1;
    checkOutput("add_write_en", rf_write_en, 1);
    checkOutput("add_fwd_valid", fwd_valid, 1);
    checkOutput("add_rd_addr", rf_rd_addr, 5);
    checkOutput("add_rd_data", rf_rd_data, 32'h0000_1234);
    checkRetire("add_retire");
    fall();
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'b000, 2'b00, 32'h0);
    tick();
    checkOutput("add_write_once", rf_write_en, 0);

    // LB x10, lsb=3, response three cycles later
    fall();
    applyStimulus(1'b1, 5'd10, 1'b1, 1'b1, 3'b000, 2'b11, 32'h0);
    tick();
    checkOutput("lb_pending", load_pending, 1);
    checkOutput("lb_in_ready", bus.in_ready, 0);
    checkOutput("lb_load_rd", load_rd_addr, 10);
    checkOutput("lb_no_err", load_err, 0);
    fall();
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'b000, 2'b00, 32'h0);
    tick();
    tick();
    checkOutput("lb_wait_pending", load_pending, 1);
    checkOutput("lb_wait_write_en", rf_write_en, 0);
    fall();
    applyRsp(1'b1, 32'h80FF_FFFF);
    tick();
    exp_retire = 2;
    checkOutput("lb_write_en", rf_write_en, 1);
    checkOutput("lb_rd_addr", rf_rd_addr, 10);
    checkOutput("lb_rd_data", rf_rd_data, 32'hFFFF_FF80);
    checkOutput("lb_done_pending", load_pending, 0);
    checkRetire("lb_retire");
    fall();
    applyRsp(1'b0, 32'h0);

    // LHU x11, lsb=2
    applyStimulus(1'b1, 5'd11, 1'b1, 1'b1, 3'b101, 2'b10, 32'h0);
    tick();
    checkOutput("lhu_no_err", load_err, 0);
    fall();
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'b000, 2'b00, 32'h0);
    applyRsp(1'b1, 32'hBEEF_0000);
    tick();
    exp_retire = 3;
    checkOutput("lhu_rd_data", rf_rd_data, 32'h0000_BEEF);
    checkOutput("lhu_write_en", rf_write_en, 1);
    fall();
    applyRsp(1'b0, 32'h0);

    // LW x12, lsb=1: error pulse, word unchanged
    applyStimulus(1'b1, 5'd12, 1'b1, 1'b1, 3'b010, 2'b01, 32'h0);
    tick();
    checkOutput("lw_err_pulse", load_err, 1);
    fall();
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'b000, 2'b00, 32'h0);
    tick();
    checkOutput("lw_err_cleared", load_err, 0);
    fall();
    applyRsp(1'b1, 32'hDEAD_BEEF);
    tick();
    exp_retire = 4;
    checkOutput("lw_rd_data", rf_rd_data, 32'hDEAD_BEEF);
    checkOutput("lw_rd_addr", rf_rd_addr, 12);
    fall();
    applyRsp(1'b0, 32'h0);

    // LH x13, lsb=3: misaligned, upper half sign-extended
    applyStimulus(1'b1, 5'd13, 1'b1, 1'b1, 3'b001, 2'b11, 32'h0);
    tick();
    checkOutput("lh_mis_err", load_err, 1);
    fall();
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'b000, 2'b00, 32'h0);
    applyRsp(1'b1, 32'h8001_2345);
    tick();
    exp_retire = 5;
    checkOutput("lh_mis_data", rf_rd_data, 32'hFFFF_8001);
    fall();
    applyRsp(1'b0, 32'h0);

    // LBU x14, lsb=1
    applyStimulus(1'b1, 5'd14, 1'b1, 1'b1, 3'b100, 2'b01, 32'h0);
    tick();
    fall();
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'b000, 2'b00, 32'h0);
    applyRsp(1'b1, 32'h0000_AB00);
    tick();
    exp_retire = 6;
    checkOutput("lbu_rd_data", rf_rd_data, 32'h0000_00AB);
    fall();
    applyRsp(1'b0, 32'h0);

    // Back-to-back: x0 then x7
    applyStimulus(1'b1, 5'd0, 1'b1, 1'b0, 3'b000, 2'b00, 32'h0000_AAAA);
    tick();
    exp_retire = 7;
    checkOutput("x0_no_write", rf_write_en, 0);
    checkRetire("x0_retire");
    fall();
    applyStimulus(1'b1, 5'd7, 1'b1, 1'b0, 3'b000, 2'b00, 32'h0000_0077);
    tick();
    exp_retire = 8;
    checkOutput("x7_write_en", rf_write_en, 1);
    checkOutput("x7_rd_addr", rf_rd_addr, 7);
    checkOutput("x7_rd_data", rf_rd_data, 32'h0000_0077);
    checkRetire("x7_retire");

    // we=0 still retires; then a stray response in IDLE
    fall();
    applyStimulus(1'b1, 5'd3, 1'b0, 1'b0, 3'b000, 2'b00, 32'h0000_0033);
    tick();
    exp_retire = 9;
    checkOutput("nowe_write_en", rf_write_en, 0);
    checkRetire("nowe_retire");
    fall();
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'b000, 2'b00, 32'h0);
    applyRsp(1'b1, 32'h1111_1111);
    tick();
    checkOutput("stray_idle_write_en", rf_write_en, 0);
    checkRetire("stray_idle_retire");
    fall();
    applyRsp(1'b0, 32'h0);

    // Reset while a load waits, then a stray response
    applyStimulus(1'b1, 5'd9, 1'b1, 1'b1, 3'b010, 2'b00, 32'h0);
    tick();
    checkOutput("rstwait_pending", load_pending, 1);
    fall();
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'b000, 2'b00, 32'h0);
    rst_n = 1'b0;
    #1;
    exp_retire = 0;
    checkOutput("rstwait_pending_clr", load_pending, 0);
    checkOutput("rstwait_in_ready", bus.in_ready, 1);
    checkOutput("rstwait_rd_addr", rf_rd_addr, 0);
    checkRetire("rstwait_retire");
    fall();
    rst_n = 1'b1;
    fall();
    applyRsp(1'b1, 32'h5555_5555);
    tick();
    checkOutput("rstwait_stray_write_en", rf_write_en, 0);
    checkOutput("rstwait_stray_ready", bus.in_ready, 1);
    checkRetire("rstwait_stray_retire");
    fall();
    applyRsp(1'b0, 32'h0);

    // Sixteen back-to-back retires wrap the 4-bit counter
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 5'd1, 1'b1, 1'b0, 3'b000, 2'b00, 32'h100 + 32'(i));
      tick();
      exp_retire++;
      if (i == 14) checkOutput("wrap_short_15", {28'd0, s_retire_count}, 15);
      fall();
    end
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'b000, 2'b00, 32'h0);
    checkOutput("wrap_full_16", retire_count, 16);
    checkOutput("wrap_short_0", {28'd0, s_retire_count}, 0);
    checkOutput("wrap_last_data", rf_rd_data, 32'h0000_010F);
    tick();
    checkOutput("wrap_idle_write_en", rf_write_en, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
